// File: rtl/sub_arbiter.sv
// Two-requester round-robin front end for a single 64-bit subtractor.
// Flow: IDLE captures the winner's operands, EXEC computes, RESP holds the result until res_ready.
module sub_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [63:0] a0_in,
  input  logic [63:0] b0_in,
  output logic        gnt0,
  input  logic        req1,
  input  logic [63:0] a1_in,
  input  logic [63:0] b1_in,
  output logic        gnt1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [63:0] difference,
  output logic        carry_out,
  output logic        zero_flag,
  output logic        neg_flag,
  output logic        ovf_flag,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  // Handshake: the result transfers on a rising edge where res_valid && res_ready;
  // res_valid never depends on res_ready, and the result holds until it transfers.
  state_e      state_q, state_d;
  logic        last_q;
  logic        win;
  logic        any_req;
  logic [63:0] a_q, b_q;
  logic        gnt0_q, gnt1_q, res_id_q;
  logic [63:0] diff_q;
  logic        carry_q, zero_q, neg_q, ovf_q;
  logic [64:0] sum;

  assign any_req = req0 | req1;

  // With both requesting, the one that did not win last time takes the slot.
  always_comb begin
    win = 1'b0;
    if (req0 && !req1)      win = 1'b0;
    else if (req1 && !req0) win = 1'b1;
    else if (req0 && req1)  win = ~last_q;
  end

  assign sum = {1'b0, a_q} + {1'b0, ~b_q} + 65'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    res_valid = (state_q == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      res_id_q <= 1'b0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      if (state_q == IDLE && any_req) begin
        a_q      <= win ? a1_in : a0_in;
        b_q      <= win ? b1_in : b0_in;
        res_id_q <= win;
        last_q   <= win;
        gnt0_q   <= ~win;
        gnt1_q   <= win;
      end
      if (state_q == EXEC) begin
        diff_q  <= sum[63:0];
        carry_q <= sum[64];
        zero_q  <= (sum[63:0] == 64'd0);
        neg_q   <= sum[63];
        ovf_q   <= (a_q[63] != b_q[63]) && (sum[63] != a_q[63]);
      end
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign res_id     = res_id_q;
  assign difference = diff_q;
  assign carry_out  = carry_q;
  assign zero_flag  = zero_q;
  assign neg_flag   = neg_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_sub_arbiter.sv
// Bench for sub_arbiter: scenario tasks plus a result scoreboard fed by a reference model.
module tb_sub_arbiter;

  logic        clk, rst_n;
  logic        req0, req1, gnt0, gnt1;
  logic [63:0] a0_in, b0_in, a1_in, b1_in;
  logic        res_valid, res_ready, res_id;
  logic [63:0] difference;
  logic        carry_out, zero_flag, neg_flag, ovf_flag, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // {id, difference, carry, zero, neg, ovf}
  logic [68:0] exp_q[$];

  sub_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0_in(a0_in), .b0_in(b0_in), .gnt0(gnt0),
    .req1(req1), .a1_in(a1_in), .b1_in(b1_in), .gnt1(gnt1),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .difference(difference), .carry_out(carry_out), .zero_flag(zero_flag),
    .neg_flag(neg_flag), .ovf_flag(ovf_flag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [68:0] model(input logic id, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] d;
    logic [64:0] s;
    d = a - b;
    s = {a[63], a} - {b[63], b};
    return {id, d, (a >= b), (d == 64'd0), d[63], (s[64] != s[63])};
  endfunction

  // Scoreboard: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      logic [68:0] act, exp;
      act = {res_id, difference, carry_out, zero_flag, neg_flag, ovf_flag};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got %h, want no result", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL result: got id=%0d diff=%h c=%b z=%b n=%b v=%b, want id=%0d diff=%h c=%b z=%b n=%b v=%b",
                   act[68], act[67:4], act[3], act[2], act[1], act[0],
                   exp[68], exp[67:4], exp[3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  // Drives a single request for one IDLE sampling edge, then withdraws it.
  task automatic issue(input logic sel, input logic [63:0] a, input logic [63:0] b, input bit push);
    @(posedge clk); #1;
    if (sel) begin req1 = 1'b1; a1_in = a; b1_in = b; end
    else     begin req0 = 1'b1; a0_in = a; b0_in = b; end
    if (push) exp_q.push_back(model(sel, a, b));
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt0, gnt1, res_valid, busy, res_id, difference, carry_out, zero_flag, neg_flag, ovf_flag} !== 73'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b%b v=%b busy=%b id=%b diff=%h flags=%b%b%b%b, want all 0",
               gnt0, gnt1, res_valid, busy, res_id, difference, carry_out, zero_flag, neg_flag, ovf_flag);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic_req0();
    issue(1'b0, 64'd54, 64'd17, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1, res_valid, busy} !== 4'b1001) begin
      n_fail++;
      $display("FAIL basic0_gnt: got gnt0=%b gnt1=%b v=%b busy=%b, want 1 0 0 1", gnt0, gnt1, res_valid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (!(res_valid === 1'b1 && gnt0 === 1'b0 && difference === 64'd37 && res_id === 1'b0)) begin
      n_fail++;
      $display("FAIL basic0_result: got v=%b gnt0=%b diff=%0d id=%b, want 1 0 37 0", res_valid, gnt0, difference, res_id);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, res_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic0_idle: got busy=%b v=%b, want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_basic_req1();
    issue(1'b1, 64'd10, 64'd17, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic1_gnt: got gnt0=%b gnt1=%b, want 0 1", gnt0, gnt1);
    end
    @(negedge clk);
    n_checks++;
    if (!(res_valid === 1'b1 && difference === 64'hFFFF_FFFF_FFFF_FFF9 && carry_out === 1'b0 &&
          neg_flag === 1'b1 && ovf_flag === 1'b0 && res_id === 1'b1)) begin
      n_fail++;
      $display("FAIL basic1_result: got v=%b diff=%h c=%b n=%b v=%b id=%b, want 1 fffffffffffffff9 0 1 0 1",
               res_valid, difference, carry_out, neg_flag, ovf_flag, res_id);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[3] = '{0, 1, 0};
    int grants = 0;
    logic id;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back(model(1'b0, 64'd100, 64'd1));
    exp_q.push_back(model(1'b1, 64'd7, 64'd300));
    exp_q.push_back(model(1'b0, 64'd5, 64'd5));
    @(posedge clk); #1;
    req0 = 1'b1; a0_in = 64'd100; b0_in = 64'd1;
    req1 = 1'b1; a1_in = 64'd7;   b1_in = 64'd300;
    for (int cyc = 0; cyc < 40 && grants < 3; cyc++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        id = gnt1;
        n_checks++;
        if ((gnt0 && gnt1) || (int'(id) != exp_order[grants])) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: got gnt0=%b gnt1=%b, want grant to %0d", grants, gnt0, gnt1, exp_order[grants]);
        end
        if (!id && grants == 0) begin a0_in = 64'd5; b0_in = 64'd5; end
        else if (!id)           req0 = 1'b0;
        else                    req1 = 1'b0;
        grants++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    n_checks++;
    if (grants != 3) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d grants, want 3", grants);
    end
    drain(10);
  endtask

  task automatic test_back_to_back();
    int gnt_cyc[$];
    @(posedge clk); #1;
    req0 = 1'b1; a0_in = 64'd1000; b0_in = 64'd999;
    for (int cyc = 0; cyc < 30 && gnt_cyc.size() < 3; cyc++) begin
      @(negedge clk);
      if (gnt0) begin
        gnt_cyc.push_back(cyc);
        exp_q.push_back(model(1'b0, 64'd1000, 64'd999));
      end
    end
    req0 = 1'b0;
    n_checks++;
    if (gnt_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d grants, want 3", gnt_cyc.size());
    end else begin
      n_checks++;
      if (gnt_cyc[1] - gnt_cyc[0] != 3 || gnt_cyc[2] - gnt_cyc[1] != 3) begin
        n_fail++;
        $display("FAIL b2b_interval: got %0d and %0d cycles, want 3 and 3",
                 gnt_cyc[1] - gnt_cyc[0], gnt_cyc[2] - gnt_cyc[1]);
      end
    end
    drain(10);
  endtask

  task automatic test_equal();
    issue(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (!(res_valid === 1'b1 && difference === 64'd0 && zero_flag === 1'b1 && carry_out === 1'b1)) begin
      n_fail++;
      $display("FAIL equal: got v=%b diff=%h z=%b c=%b, want 1 0 1 1", res_valid, difference, zero_flag, carry_out);
    end
  endtask

  task automatic test_stall();
    logic [68:0] snap;
    @(posedge clk); #1 res_ready = 1'b0;
    issue(1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    snap = {res_id, difference, carry_out, zero_flag, neg_flag, ovf_flag};
    n_checks++;
    if (!(res_valid === 1'b1 && difference === 64'h7FFF_FFFF_FFFF_FFFF && ovf_flag === 1'b1 && carry_out === 1'b1)) begin
      n_fail++;
      $display("FAIL stall_value: got v=%b diff=%h v=%b c=%b, want 1 7fffffffffffffff 1 1",
               res_valid, difference, ovf_flag, carry_out);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || {res_id, difference, carry_out, zero_flag, neg_flag, ovf_flag} !== snap) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b diff=%h, want 1 %h", i, res_valid, difference, snap[67:4]);
      end
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || {res_id, difference, carry_out, zero_flag, neg_flag, ovf_flag} !== snap) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b diff=%h, want 1 %h", res_valid, difference, snap[67:4]);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, res_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_idle: got busy=%b v=%b, want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_reset_exec();
    issue(1'b1, 64'd99, 64'd3, 1'b0);
    @(negedge clk);
    n_checks++;
    if (gnt1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_exec_gnt: got gnt1=%b, want 1", gnt1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt0, gnt1, res_valid, busy, res_id, difference, carry_out, zero_flag, neg_flag, ovf_flag} !== 73'd0) begin
      n_fail++;
      $display("FAIL rst_exec_outputs: got gnt=%b%b v=%b busy=%b id=%b diff=%h flags=%b%b%b%b, want all 0",
               gnt0, gnt1, res_valid, busy, res_id, difference, carry_out, zero_flag, neg_flag, ovf_flag);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({res_valid, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_exec_quiet[%0d]: got v=%b busy=%b, want 0 0", i, res_valid, busy);
      end
    end
    issue(1'b0, 64'd500, 64'd123, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_exec_next_gnt: got gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
    end
    drain(6);
  endtask

  task automatic test_random();
    logic sel;
    logic [63:0] a, b;
    for (int k = 0; k < 8; k++) begin
      sel = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = (k == 3) ? a : {$urandom, $urandom};
      issue(sel, a, b, 1'b1);
      @(negedge clk);
      n_checks++;
      if ({gnt0, gnt1} !== (sel ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL random_gnt[%0d]: got gnt0=%b gnt1=%b, want grant to %0d", k, gnt0, gnt1, sel);
      end
      drain(6);
    end
  endtask

  initial begin
    req0 = 1'b0; req1 = 1'b0;
    a0_in = '0; b0_in = '0; a1_in = '0; b1_in = '0;
    res_ready = 1'b1;
    test_reset();
    test_basic_req0();
    test_basic_req1();
    test_round_robin();
    test_back_to_back();
    test_equal();
    test_stall();
    test_reset_exec();
    test_random();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
